pad_pattern_sequencer: RTL and testbench
========================================

# pad_pattern_sequencer

Controller that sits directly upstream of the 12-word × 12-bit pattern SRAM and owns its Address, RW and Din inputs. It toggles pad bits in a selected step (edit mode), clears all steps on request, and steps through words 0–11 at a fixed tempo (play mode). It presents the current step's 12-bit pad pattern to the LED/sound stage downstream.

## Interface
- TEMPO_DIV, default 1000000: CLK cycles per playback step; legal range ≥ 2.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- Play  in  1  level: 1 = play mode, 0 = edit mode.
- Pad  in  12  pad-press strobes, one-cycle pulses, already debounced; bit i toggles pad i.
- StepSel  in  4  step to edit or view in edit mode.
- Clear  in  1  one-cycle pulse; zero all 12 words.
- MemDout  in  12  SRAM read data; combinational function of the SRAM's Address.
- Address  out  4  SRAM address.
- RW  out  1  SRAM write enable, 1 = write.
- Din  out  12  SRAM write data.
- Step  out  4  current playback step, 0–11.
- StepTick  out  1  one-cycle pulse on each step advance.
- Pattern  out  12  registered pattern of the viewed step.
- Busy  out  1  high while a write sequence is in progress.

## Operation
- States: IDLE, EDIT_WR, CLEAR, PLAY. Address, RW and Din are Moore decodes of the state registers and are stable for the whole cycle.
- IDLE:
  - Address = StepSel, RW = 0, Din = 0.
  - Exits are prioritised. Clear → CLEAR. Else Play=1 → PLAY with Step=0 and divider=0. Else Pad≠0 and StepSel<12 → EDIT_WR, latching mask=Pad and step=StepSel.
  - Pad with StepSel ≥ 12 is dropped.
- EDIT_WR (1 cycle):
  - Address = latched step, RW = 1, Din = MemDout ^ mask.
  - Next state is CLEAR if Clear, else IDLE.
  - Pads arriving in this cycle are dropped.
- CLEAR (12 cycles):
  - Counter 0..11 drives Address, RW = 1, Din = 0.
  - After count 11 → IDLE.
  - Clear and Pad are ignored while in CLEAR.
- PLAY:
  - Address = Step, RW = 0.
  - Divider counts 0..TEMPO_DIV-1. At TEMPO_DIV-1 it returns to 0 and Step advances, wrapping 11 → 0, with StepTick=1 in that cycle.
  - Clear → CLEAR. Else Play=0 → IDLE with Step=0 and divider=0.
  - Pad is ignored in PLAY.
- Pattern:
  - Every cycle, Pattern <= MemDout when in IDLE with StepSel<12, or in PLAY.
  - Pattern <= 0 in IDLE with StepSel ≥ 12.
  - Pattern holds in EDIT_WR and CLEAR.
- Busy = (state == EDIT_WR) or (state == CLEAR).
- Step changes only in PLAY or on leaving it. Step resets to 0 on entering CLEAR.

## Timing
- Reset: state IDLE, Step 0, divider 0, Pattern 0, StepTick 0, Busy 0, RW 0, Address = StepSel, Din 0. The SRAM is reset by the same RST.
- Edit latency, for a Pad pulse in cycle N:
  - N+1: EDIT_WR write cycle.
  - End of N+1: SRAM updated.
  - N+2: IDLE again.
  - N+3: new value visible on Pattern.
- Clear latency, for Clear in cycle N:
  - N+1..N+12: writes to addresses 0..11.
  - N+13: IDLE.
  - N+14: Pattern = 0.
- Play entry: Play sampled high in IDLE at cycle N.
  - N+1: PLAY with Step 0; Pattern = word 0 from N+2.
  - First StepTick at N+TEMPO_DIV, then every TEMPO_DIV cycles.
  - Pattern follows Step with 1-cycle latency.
- Simultaneous events:
  - Clear beats Play and Pad.
  - Play beats Pad.
  - Clear during PLAY aborts playback. If Play is still high when CLEAR ends, PLAY re-enters from Step 0 one cycle after IDLE.
- Reset mid-CLEAR or mid-EDIT_WR aborts to IDLE at once. No further writes occur.

## Test plan
- Reset, then Pad=12'h001 with StepSel=3 → one cycle with RW=1, Address=3, Din=12'h001; Pattern=12'h001 three cycles after the pulse. Repeat the pulse → word 3 = 12'h000.
- Set word 5 = 12'hA50, then Pad=12'h00F with StepSel=5 → Din=12'hA5F. Pad=12'h800 with StepSel=13 → no RW pulse, Pattern=0.
- Fill all words nonzero, then pulse Clear → Busy high for exactly 12 cycles, Address 0..11, Din=0; every word reads 0 afterwards.
- With TEMPO_DIV=4, words i=12'h100+i, and Play=1 → StepTick every 4 cycles; Step 0→1→…→11→0; Pattern tracks 12'h100..12'h10B and wraps.
- Same cycle Clear+Pad+Play in IDLE → CLEAR runs and the Pad is dropped; PLAY starts after CLEAR if Play is still high. Pad in PLAY → no write.
- Assert RST at the 6th CLEAR cycle → next cycle IDLE, RW=0, Busy=0; SRAM words all 0 from SRAM reset.

Source files
------------

// File: rtl/pad_pattern_sequencer.sv
// Pattern SRAM controller: toggles pad bits of a selected step, clears all
// twelve words on request, and plays the steps back at a fixed tempo.
// Owns the SRAM Address/RW/Din and presents the viewed step on Pattern.
module pad_pattern_sequencer #(
  parameter int TEMPO_DIV = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Play,
  input  logic [11:0] Pad,
  input  logic [3:0]  StepSel,
  input  logic        Clear,
  input  logic [11:0] MemDout,
  output logic [3:0]  Address,
  output logic        RW,
  output logic [11:0] Din,
  output logic [3:0]  Step,
  output logic        StepTick,
  output logic [11:0] Pattern,
  output logic        Busy
);

  localparam int               DIV_W     = (TEMPO_DIV > 2) ? $clog2(TEMPO_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TEMPO_DIV - 1);
  localparam logic [3:0]       LAST_STEP = 4'd11;

  typedef enum logic [1:0] {IDLE, EDIT_WR, CLEAR, PLAY} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       step_reg, step_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [11:0]      mask_reg, mask_next;
  logic [3:0]       edit_step_reg, edit_step_next;
  logic [3:0]       clr_cnt_reg, clr_cnt_next;
  logic [11:0]      pattern_reg, pattern_next;
  logic             step_sel_valid;

  assign step_sel_valid = (StepSel < 4'd12);

  // State and datapath registers; reset returns everything to an idle, empty view
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      div_reg       <= '0;
      mask_reg      <= '0;
      edit_step_reg <= '0;
      clr_cnt_reg   <= '0;
      pattern_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      div_reg       <= div_next;
      mask_reg      <= mask_next;
      edit_step_reg <= edit_step_next;
      clr_cnt_reg   <= clr_cnt_next;
      pattern_reg   <= pattern_next;
    end
  end

  // Next-state logic: Clear outranks Play, which outranks a pad edit
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    div_next       = div_reg;
    mask_next      = mask_reg;
    edit_step_next = edit_step_reg;
    clr_cnt_next   = clr_cnt_reg;
    pattern_next   = pattern_reg;
    case (state_reg)
      IDLE: begin
        pattern_next = step_sel_valid ? MemDout : 12'h000;
        if (Clear) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          step_next    = '0;
        end else if (Play) begin
          state_next = PLAY;
          step_next  = '0;
          div_next   = '0;
        end else if ((Pad != 12'h000) && step_sel_valid) begin
          state_next     = EDIT_WR;
          mask_next      = Pad;
          edit_step_next = StepSel;
        end
      end
      EDIT_WR: begin
        if (Clear) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          step_next    = '0;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt_reg == LAST_STEP) begin
          state_next = IDLE;
        end else begin
          clr_cnt_next = clr_cnt_reg + 4'd1;
        end
      end
      PLAY: begin
        pattern_next = MemDout;
        if (Clear) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          step_next    = '0;
          div_next     = '0;
        end else if (!Play) begin
          state_next = IDLE;
          step_next  = '0;
          div_next   = '0;
        end else if (div_reg == DIV_LAST) begin
          div_next  = '0;
          step_next = (step_reg == LAST_STEP) ? 4'd0 : step_reg + 4'd1;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // SRAM port decode from the state registers (Din also folds in read data for edits)
  always_comb begin
    Address = StepSel;
    RW      = 1'b0;
    Din     = 12'h000;
    case (state_reg)
      EDIT_WR: begin
        Address = edit_step_reg;
        RW      = 1'b1;
        Din     = MemDout ^ mask_reg;
      end
      CLEAR: begin
        Address = clr_cnt_reg;
        RW      = 1'b1;
      end
      PLAY:    Address = step_reg;
      default: Address = StepSel;
    endcase
  end

  assign Step     = step_reg;
  assign StepTick = (state_reg == PLAY) && (div_reg == DIV_LAST);
  assign Pattern  = pattern_reg;
  assign Busy     = (state_reg == EDIT_WR) || (state_reg == CLEAR);

endmodule

// File: tb/tb_pad_pattern_sequencer.sv
// Bench for pad_pattern_sequencer: behavioural SRAM plus a word-level
// reference of what the pattern memory should hold.
module tb_pad_pattern_sequencer;

  localparam int TD = 4;

  logic        CLK;
  logic        RST;
  logic        Play;
  logic [11:0] Pad;
  logic [3:0]  StepSel;
  logic        Clear;
  logic [11:0] MemDout;
  logic [3:0]  Address;
  logic        RW;
  logic [11:0] Din;
  logic [3:0]  Step;
  logic        StepTick;
  logic [11:0] Pattern;
  logic        Busy;

  int checks = 0;
  int passes = 0;

  logic [11:0] sram    [16];
  logic [11:0] ref_mem [16];

  pad_pattern_sequencer #(.TEMPO_DIV(TD)) dut (
    .CLK(CLK), .RST(RST), .Play(Play), .Pad(Pad), .StepSel(StepSel),
    .Clear(Clear), .MemDout(MemDout), .Address(Address), .RW(RW),
    .Din(Din), .Step(Step), .StepTick(StepTick), .Pattern(Pattern),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 12 x 12 SRAM: combinational read, write on clock, cleared by the shared reset
  always_comb MemDout = (Address < 4'd12) ? sram[Address] : 12'h000;
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) sram[i] <= 12'h000;
    end else if (RW && (Address < 4'd12)) begin
      sram[Address] <= Din;
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 12'h000;
  endtask

  // One pad pulse in IDLE, checked through write cycle and Pattern update
  task automatic press_pad(input logic [3:0] s, input logic [11:0] m);
    logic [11:0] exp_din;
    logic [11:0] exp_pat;
    exp_din = (s < 4'd12) ? (ref_mem[s] ^ m) : 12'h000;
    StepSel = s;
    Pad     = m;
    @(negedge CLK);
    checks++;
    if (RW !== 1'b0 || Busy !== 1'b0) $display("FAIL pad_idle: RW=%b Busy=%b expected 0 0", RW, Busy);
    else passes++;
    nxt();
    Pad = 12'h000;
    @(negedge CLK);
    checks++;
    if (s < 4'd12) begin
      if (RW !== 1'b1 || Address !== s || Din !== exp_din || Busy !== 1'b1)
        $display("FAIL edit_write: RW=%b Address=%0d Din=%h Busy=%b expected RW=1 Address=%0d Din=%h Busy=1",
                 RW, Address, Din, Busy, s, exp_din);
      else passes++;
      ref_mem[s] = exp_din;
    end else begin
      if (RW !== 1'b0 || Busy !== 1'b0 || Pattern !== 12'h000)
        $display("FAIL dropped_pad: RW=%b Busy=%b Pattern=%h expected 0 0 000", RW, Busy, Pattern);
      else passes++;
    end
    nxt();
    @(negedge CLK);
    checks++;
    if (RW !== 1'b0 || Busy !== 1'b0) $display("FAIL edit_return: RW=%b Busy=%b expected 0 0", RW, Busy);
    else passes++;
    nxt();
    @(negedge CLK);
    exp_pat = (s < 4'd12) ? ref_mem[s] : 12'h000;
    checks++;
    if (Pattern !== exp_pat) $display("FAIL edit_pattern: step %0d Pattern=%h expected %h", s, Pattern, exp_pat);
    else passes++;
    $display("edit step=%0d mask=%h -> Pattern=%h", s, m, Pattern);
    nxt();
  endtask

  task automatic load_word(input logic [3:0] s, input logic [11:0] target);
    if ((ref_mem[s] ^ target) != 12'h000) press_pad(s, ref_mem[s] ^ target);
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (sram[i] !== ref_mem[i]) $display("FAIL %s: word %0d = %h expected %h", tag, i, sram[i], ref_mem[i]);
      else passes++;
    end
    $display("memory compare %s done", tag);
  endtask

  task automatic test_reset();
    RST = 1'b1; Play = 1'b0; Pad = 12'h000; StepSel = 4'd7; Clear = 1'b0;
    nxt();
    nxt();
    @(negedge CLK);
    checks++;
    if (Step !== 4'd0 || StepTick !== 1'b0 || Pattern !== 12'h000 || Busy !== 1'b0 ||
        RW !== 1'b0 || Din !== 12'h000 || Address !== 4'd7)
      $display("FAIL reset: Step=%0d Tick=%b Pattern=%h Busy=%b RW=%b Din=%h Address=%0d expected 0 0 000 0 0 000 7",
               Step, StepTick, Pattern, Busy, RW, Din, Address);
    else passes++;
    $display("reset checked");
    nxt();
    RST = 1'b0;
    ref_clear();
  endtask

  task automatic test_edit();
    press_pad(4'd3, 12'h001);
    press_pad(4'd3, 12'h001);
    load_word(4'd5, 12'hA50);
    press_pad(4'd5, 12'h00F);
    press_pad(4'd13, 12'h800);
    compare_mem("edit");
  endtask

  task automatic test_random_edits();
    for (int k = 0; k < 16; k++)
      press_pad(4'($urandom_range(0, 15)), 12'($urandom_range(1, 4095)));
    compare_mem("random_edits");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 12; i++) load_word(4'(i), 12'($urandom_range(1, 4095)));
    StepSel = 4'd4;
    Clear   = 1'b1;
    nxt();
    Clear = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if (Busy !== 1'b1 || RW !== 1'b1 || Address !== 4'(k) || Din !== 12'h000)
        $display("FAIL clear_write: Busy=%b RW=%b Address=%0d Din=%h expected 1 1 %0d 000", Busy, RW, Address, Din, k);
      else passes++;
      nxt();
    end
    ref_clear();
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || RW !== 1'b0) $display("FAIL clear_end: Busy=%b RW=%b expected 0 0", Busy, RW);
    else passes++;
    nxt();
    @(negedge CLK);
    checks++;
    if (Pattern !== 12'h000) $display("FAIL clear_pattern: Pattern=%h expected 000", Pattern);
    else passes++;
    $display("clear sequence checked");
    nxt();
    compare_mem("clear");
  endtask

  task automatic test_play();
    int unsigned exp_step;
    int unsigned prev_step;
    for (int i = 0; i < 12; i++) load_word(4'(i), 12'h100 + 12'(i));
    StepSel = 4'd9;
    Play    = 1'b1;
    for (int j = 0; j < 12 * TD + 8; j++) begin
      nxt();
      @(negedge CLK);
      exp_step = (j / TD) % 12;
      checks++;
      if (Step !== 4'(exp_step) || StepTick !== (j % TD == TD - 1) || Address !== 4'(exp_step) || RW !== 1'b0)
        $display("FAIL play_step: j=%0d Step=%0d Tick=%b Address=%0d RW=%b expected Step=%0d Tick=%b",
                 j, Step, StepTick, Address, RW, exp_step, (j % TD == TD - 1));
      else passes++;
      if (j >= 1) begin
        prev_step = ((j - 1) / TD) % 12;
        checks++;
        if (Pattern !== ref_mem[prev_step]) $display("FAIL play_pattern: j=%0d Pattern=%h expected %h", j, Pattern, ref_mem[prev_step]);
        else passes++;
      end
      $display("play j=%0d Step=%0d Tick=%b Pattern=%h", j, Step, StepTick, Pattern);
    end
    nxt();
    Play = 1'b0;
    nxt();
    @(negedge CLK);
    checks++;
    if (Step !== 4'd0 || StepTick !== 1'b0 || Address !== 4'd9)
      $display("FAIL play_exit: Step=%0d Tick=%b Address=%0d expected 0 0 9", Step, StepTick, Address);
    else passes++;
    nxt();
  endtask

  task automatic test_simultaneous();
    load_word(4'd2, 12'($urandom_range(1, 4095)));
    StepSel = 4'd2;
    Clear   = 1'b1;
    Play    = 1'b1;
    Pad     = 12'($urandom_range(1, 4095));
    nxt();
    Clear = 1'b0;
    Pad   = 12'h000;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if (Busy !== 1'b1 || RW !== 1'b1 || Address !== 4'(k) || Din !== 12'h000 || Step !== 4'd0)
        $display("FAIL simul_clear: Busy=%b RW=%b Address=%0d Din=%h Step=%0d expected 1 1 %0d 000 0",
                 Busy, RW, Address, Din, Step, k);
      else passes++;
      nxt();
    end
    ref_clear();
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || RW !== 1'b0 || Address !== 4'd2) $display("FAIL simul_idle: Busy=%b RW=%b Address=%0d expected 0 0 2", Busy, RW, Address);
    else passes++;
    nxt();
    @(negedge CLK);
    checks++;
    if (Step !== 4'd0 || Address !== 4'd0 || Busy !== 1'b0) $display("FAIL simul_play: Step=%0d Address=%0d Busy=%b expected 0 0 0", Step, Address, Busy);
    else passes++;
    $display("simultaneous clear+play+pad checked");
    for (int k = 0; k < 5; k++) begin
      nxt();
      Pad     = 12'($urandom_range(1, 4095));
      StepSel = 4'($urandom_range(0, 11));
      @(negedge CLK);
      checks++;
      if (RW !== 1'b0 || Busy !== 1'b0) $display("FAIL play_pad: RW=%b Busy=%b expected 0 0", RW, Busy);
      else passes++;
    end
    nxt();
    Pad = 12'h000;
    @(negedge CLK);
    checks++;
    if (RW !== 1'b0) $display("FAIL play_pad_late: RW=%b expected 0", RW);
    else passes++;
    nxt();
    Clear = 1'b1;
    nxt();
    Clear = 1'b0;
    Play  = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b1 || Step !== 4'd0 || Address !== 4'd0) $display("FAIL play_abort: Busy=%b Step=%0d Address=%0d expected 1 0 0", Busy, Step, Address);
    else passes++;
    repeat (13) nxt();
    compare_mem("simultaneous");
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 12; i++) load_word(4'(i), 12'($urandom_range(1, 4095)));
    StepSel = 4'd1;
    Clear   = 1'b1;
    nxt();
    Clear = 1'b0;
    repeat (5) nxt();
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b1 || Address !== 4'd5) $display("FAIL mid_clear: Busy=%b Address=%0d expected 1 5", Busy, Address);
    else passes++;
    nxt();
    RST = 1'b0;
    ref_clear();
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || RW !== 1'b0 || Step !== 4'd0 || Address !== 4'd1)
      $display("FAIL reset_abort: Busy=%b RW=%b Step=%0d Address=%0d expected 0 0 0 1", Busy, RW, Step, Address);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      nxt();
      @(negedge CLK);
      checks++;
      if (RW !== 1'b0) $display("FAIL post_reset_write: RW=%b expected 0", RW);
      else passes++;
    end
    $display("reset during clear checked");
    nxt();
    compare_mem("reset_mid_clear");
  endtask

  initial begin
    test_reset();
    test_edit();
    test_random_edits();
    test_clear();
    test_play();
    test_simultaneous();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
